// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/freeze sequencer for the 5-stage core
// Detects load-use and ID-branch operand hazards, freezes on data-memory busy, keeps stats.
module hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_uses_rs2_i,
   input  logic             id_is_branch_i,
   input  logic             id_branch_taken_i,
   input  logic             idex_memread_i,
   input  logic             idex_regwrite_i,
   input  logic [4:0]       idex_rd_i,
   input  logic             mem_stall_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_stall_o,
   output logic             idex_bubble_o,
   output logic             exmem_stall_o,
   output logic             memwb_bubble_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             timeout_o
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      BR_STALL = 2'd1,
      MEM_WAIT = 2'd2,
      ERR      = 2'd3
   } state_t;

   state_t            state_q, state_d;
   state_t            ret_q, ret_d;
   logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic match1, match2, m, lu, bh;
   logic freeze, stall;

   assign match1 = (idex_rd_i != 5'd0) && (idex_rd_i == id_rs1_i);
   assign match2 = (idex_rd_i != 5'd0) && id_uses_rs2_i && (idex_rd_i == id_rs2_i);
   assign m      = match1 || match2;
   assign lu     = idex_memread_i && m;
   assign bh     = id_is_branch_i && idex_regwrite_i && !idex_memread_i && m;

   always_comb begin
      state_d        = state_q;
      ret_d          = ret_q;
      wait_cnt_d     = wait_cnt_q;
      freeze         = 1'b0;
      stall          = 1'b0;
      pc_write_o     = 1'b1;
      ifid_write_o   = 1'b1;
      ifid_flush_o   = 1'b0;
      idex_stall_o   = 1'b0;
      idex_bubble_o  = 1'b0;
      exmem_stall_o  = 1'b0;
      memwb_bubble_o = 1'b0;

      case (state_q)
         RUN, BR_STALL: begin
            if (mem_stall_i) begin
               freeze     = 1'b1;
               ret_d      = state_q;
               state_d    = MEM_WAIT;
               wait_cnt_d = TO_W'(1);
            end else if (state_q == BR_STALL) begin
               stall   = 1'b1;
               state_d = RUN;
            end else if (lu && id_is_branch_i) begin
               stall   = 1'b1;
               state_d = BR_STALL;
            end else if (lu || bh) begin
               stall = 1'b1;
            end else if (id_branch_taken_i) begin
               ifid_flush_o = 1'b1;
            end
         end
         MEM_WAIT: begin
            freeze = 1'b1;
            if (!mem_stall_i) begin
               state_d    = ret_q;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == TO_W'(MEM_TIMEOUT)) begin
               state_d = ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + TO_W'(1);
            end
         end
         default: freeze = 1'b1;
      endcase

      // Freeze wins over a bubble; the two never coexist so idex_stall/idex_bubble stay exclusive.
      if (freeze) begin
         pc_write_o     = 1'b0;
         ifid_write_o   = 1'b0;
         idex_stall_o   = 1'b1;
         exmem_stall_o  = 1'b1;
         memwb_bubble_o = 1'b1;
      end else if (stall) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end

      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (ifid_flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= RUN;
         ret_q       <= RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign state_o     = state_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
   assign timeout_o   = (state_q == ERR);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with randomized stimulus
// Driver predicts each cycle from a counter-based reference model; monitor pops and compares.
module tb_hazard_ctrl;

   localparam int CW   = 5;
   localparam int TO   = 4;
   localparam int TW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic [4:0]    id_rs1_i = '0, id_rs2_i = '0, idex_rd_i = '0;
   logic          id_uses_rs2_i = 1'b0, id_is_branch_i = 1'b0, id_branch_taken_i = 1'b0;
   logic          idex_memread_i = 1'b0, idex_regwrite_i = 1'b0, mem_stall_i = 1'b0;
   logic          pc_write_o, ifid_write_o, ifid_flush_o, idex_stall_o, idex_bubble_o;
   logic          exmem_stall_o, memwb_bubble_o, timeout_o;
   logic [1:0]    state_o;
   logic [CW-1:0] stall_cnt_o, flush_cnt_o;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO), .TO_W(TW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_uses_rs2_i(id_uses_rs2_i),
      .id_is_branch_i(id_is_branch_i), .id_branch_taken_i(id_branch_taken_i),
      .idex_memread_i(idex_memread_i), .idex_regwrite_i(idex_regwrite_i),
      .idex_rd_i(idex_rd_i), .mem_stall_i(mem_stall_i),
      .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
      .idex_stall_o(idex_stall_o), .idex_bubble_o(idex_bubble_o),
      .exmem_stall_o(exmem_stall_o), .memwb_bubble_o(memwb_bubble_o),
      .state_o(state_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
      .timeout_o(timeout_o)
   );

   typedef struct {
      logic [6:0] ctrl;
      logic [1:0] st;
      int         sc;
      int         fc;
      logic       to;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: hung flag, 1-based wait length, owed second bubble, plain stat integers.
   bit   m_err = 0;
   int   m_wait = 0;
   bit   m_pend = 0;
   int   m_sc = 0;
   int   m_fc = 0;

   task automatic step(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u2, input bit br, input bit tk, input bit mr,
                       input bit rw, input logic [4:0] rd, input bit ms);
      exp_t e;
      bit   mt, lu, bh, fz, stl, fl;
      @(negedge clk);
      rst_i = rst; id_rs1_i = rs1; id_rs2_i = rs2; id_uses_rs2_i = u2;
      id_is_branch_i = br; id_branch_taken_i = tk; idex_memread_i = mr;
      idex_regwrite_i = rw; idex_rd_i = rd; mem_stall_i = ms;
      if (!rst) begin
         m_err = 0; m_wait = 0; m_pend = 0; m_sc = 0; m_fc = 0;
      end
      mt = (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
      lu = mr && mt;
      bh = br && rw && !mr && mt;
      fz = 0; stl = 0; fl = 0;
      e.st = m_err ? 2'd3 : (m_wait > 0) ? 2'd2 : m_pend ? 2'd1 : 2'd0;
      e.sc = m_sc;
      e.fc = m_fc;
      e.to = m_err;
      if (m_err) fz = 1;
      else if (m_wait > 0) begin
         fz = 1;
         if (!ms) m_wait = 0;
         else if (m_wait == TO) begin m_err = 1; m_wait = 0; end
         else m_wait++;
      end
      else if (ms) begin fz = 1; m_wait = 1; end
      else if (m_pend) begin stl = 1; m_pend = 0; end
      else if (lu && br) begin stl = 1; m_pend = 1; end
      else if (lu || bh) stl = 1;
      else if (tk) fl = 1;
      e.ctrl = {!(fz || stl), !(fz || stl), fl, fz, stl, fz, fz};
      q.push_back(e);
      if (!rst) begin
         m_err = 0; m_wait = 0; m_pend = 0;
      end else begin
         if ((fz || stl) && m_sc < CMAX) m_sc++;
         if (fl && m_fc < CMAX) m_fc++;
      end
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("ctrl", int'({pc_write_o, ifid_write_o, ifid_flush_o, idex_stall_o,
                           idex_bubble_o, exmem_stall_o, memwb_bubble_o}), int'(e.ctrl));
         chk("state", int'(state_o), int'(e.st));
         chk("stall_cnt", int'(stall_cnt_o), e.sc);
         chk("flush_cnt", int'(flush_cnt_o), e.fc);
         chk("timeout", int'(timeout_o), int'(e.to));
      end
   end

   initial begin
      int burst;
      bit ms, rst;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nop(2);
      // load-use then load feeding branch, ALU feeding branch
      step(1, 5, 7, 1, 0, 0, 1, 1, 5, 0);
      step(1, 5, 7, 1, 0, 0, 0, 0, 0, 0);
      step(1, 5, 0, 1, 1, 0, 1, 1, 5, 0);
      step(1, 5, 0, 1, 1, 0, 0, 0, 0, 0);
      step(1, 5, 0, 1, 1, 0, 0, 0, 0, 0);
      step(1, 5, 0, 1, 1, 0, 0, 1, 5, 0);
      step(1, 5, 0, 1, 1, 0, 0, 0, 0, 0);
      // taken branch alone, then coinciding with load-use
      step(1, 1, 2, 1, 1, 1, 0, 0, 0, 0);
      step(1, 6, 0, 1, 0, 1, 1, 1, 6, 0);
      nop(1);
      // memory busy during the second branch bubble
      step(1, 5, 0, 1, 1, 0, 1, 1, 5, 0);
      for (int i = 0; i < 4; i++) step(1, 5, 0, 1, 1, 0, 0, 0, 0, 1);
      step(1, 5, 0, 1, 1, 0, 0, 0, 0, 0);
      nop(2);
      // hung memory into ERR, stay there long enough to saturate the stall counter
      for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      nop(30);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nop(1);
      // reset in the middle of a memory wait
      for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      nop(1);
      burst = 0;
      for (int n = 0; n < 4000; n++) begin
         if (burst > 0) begin ms = 1; burst--; end
         else begin
            ms = 0;
            if ($urandom_range(0, 9) == 0) burst = $urandom_range(1, 7);
         end
         rst = !(($urandom_range(0, 199) == 0) || (m_err && $urandom_range(0, 15) == 0));
         step(rst, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), ms);
      end
      @(negedge clk);
      #4;
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
